// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a 2-entry registered output FIFO.
// Results and flags are computed combinationally from the inputs and stored on push.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpSlt = 3'b101;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             ill;
  } entry_t;

  // Shared adder: SUB and SLT use A + ~B + 1.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             sum_ovf;
  logic             slt_lt;

  assign is_sub   = (ALUControl == OpSub) || (ALUControl == OpSlt);
  assign b_eff    = is_sub ? ~src_b : src_b;
  assign add_full = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign sum      = add_full[WIDTH-1:0];
  assign sum_cout = add_full[WIDTH];
  assign sum_ovf  = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
  assign slt_lt   = sum[WIDTH-1] ^ sum_ovf;

  entry_t new_entry;

  always_comb begin
    new_entry = '0;
    case (ALUControl)
      OpAdd, OpSub: begin
        new_entry.res   = sum;
        new_entry.carry = sum_cout;
        new_entry.ovf   = sum_ovf;
      end
      OpAnd:   new_entry.res = src_a & src_b;
      OpOr:    new_entry.res = src_a | src_b;
      OpSlt:   new_entry.res = {{(WIDTH-1){1'b0}}, slt_lt};
      default: new_entry.ill = 1'b1;
    endcase
  end

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push;
  logic       pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  entry_t head;
  assign head     = mem_q[rd_ptr_q];
  assign result   = head.res;
  assign zero     = (head.res == '0);
  assign negative = head.res[WIDTH-1];
  assign carry    = head.carry;
  assign overflow = head.ovf;
  assign illegal  = head.ill;

endmodule
